// File: rtl/stopwatch_timer_pkg.sv
// Shared state/mode encodings for the stopwatch timebase, so command and display layers decode identically.
// No logic, no latency; no backpressure.
package stopwatch_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // States from which a start request reloads the counter and latches the mode.
  function automatic logic is_loadable(input state_t s);
    return (s == ST_IDLE) || (s == ST_EXPIRED);
  endfunction

endpackage

// File: rtl/stopwatch_timer_tick_gen.sv
// Prescaler: tick every PRESCALE enabled cycles, phase held while en is low, zeroed by clr/rst.
// tick is combinational from the divider register; no backpressure.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] div;

  assign tick = en && (div == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else if (en) begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// Run/pause/expire controller with up/down counter, lap capture and prescaled step; outputs registered,
// status pulses one cycle after the causing edge; no backpressure, level inputs re-trigger every cycle.
module stopwatch_timer
  import stopwatch_timer_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             mode_down,
  input  logic [CNT_W-1:0] load_val,
  output logic [1:0]       state,
  output logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] lap_val,
  output logic             lap_valid,
  output logic             rollover,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  state_t st;
  logic   mode_q;
  logic   tick;
  logic   load;

  assign state    = st;
  assign count_en = (st == ST_RUNNING);
  assign load     = start && !clear && is_loadable(st);

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (count_en),
    .clr  (clear || load),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      mode_q    <= MODE_UP;
      count     <= '0;
      lap_val   <= '0;
      lap_valid <= 1'b0;
      rollover  <= 1'b0;
      expired   <= 1'b0;
    end else begin
      rollover  <= 1'b0;
      expired   <= 1'b0;
      lap_valid <= 1'b0;

      if (lap && !clear && (st == ST_RUNNING || st == ST_PAUSED)) begin
        lap_val   <= count;
        lap_valid <= 1'b1;
      end

      if (clear) begin
        st    <= ST_IDLE;
        count <= '0;
      end else begin
        case (st)
          ST_IDLE, ST_EXPIRED: begin
            if (start) begin
              mode_q <= mode_down;
              if (mode_down == MODE_DOWN) begin
                count <= load_val;
                if (load_val == '0) begin
                  st      <= ST_EXPIRED;
                  expired <= 1'b1;
                end else begin
                  st <= ST_RUNNING;
                end
              end else begin
                count <= '0;
                st    <= ST_RUNNING;
              end
            end
          end
          ST_RUNNING: begin
            // A step due on this edge lands even when stop pauses us.
            if (tick) begin
              if (mode_q == MODE_DOWN) begin
                count <= count - ONE;
              end else begin
                count    <= count + ONE;
                rollover <= (count == ALL_ONES);
              end
            end
            if (stop) begin
              st <= ST_PAUSED;
            end else if (tick && mode_q == MODE_DOWN && count == ONE) begin
              st      <= ST_EXPIRED;
              expired <= 1'b1;
            end
          end
          ST_PAUSED: begin
            if (start) st <= ST_RUNNING;
          end
          default: begin
            st <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
